// File: rtl/conf_int_mac_dot_seq_pkg.sv
// Shared definitions for the MAC dot-product sequencer.
// Holds the FSM state encoding and the default datapath geometry.
// Imported by the sequencer and its combinational core.
package conf_int_mac_dot_seq_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int PN_DEFAULT    = 6;
  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conf_int_mac_core.sv
// Combinational multiply-accumulate step d = F(a, b, c, apx).
// Latency: zero cycles, purely combinational.
// Backpressure: none, the sequencer decides when the result is captured.
module conf_int_mac_core #(
  parameter int DW = 16,
  parameter int PN = 6
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic          apx,
  output logic [DW-1:0] d
);

  logic [DW-1:0] a_sh;
  logic [DW-1:0] b_sh;
  logic [DW-1:0] c_sh;
  logic [DW-1:0] apx_sum;
  logic [DW-1:0] acc_sum;

  // Approximate mode drops the low PN bits of each operand and the low 2*PN
  // bits of the accumulator, then restores the scale; all arithmetic wraps at DW.
  always_comb begin
    a_sh    = a >> PN;
    b_sh    = b >> PN;
    c_sh    = c >> (2 * PN);
    apx_sum = (a_sh * b_sh) + c_sh;
    acc_sum = (a * b) + c;
    d       = apx ? (apx_sum << (2 * PN)) : acc_sum;
  end

endmodule

// File: rtl/conf_int_mac_dot_seq.sv
// Job sequencer: accepts a job, folds len operand pairs through the MAC core, returns the sum.
// Latency: one cycle per operand pair; result valid the cycle after the last pair (len=0: next cycle).
// Backpressure: start and operands are only accepted when ready; the result holds until res_ready.
module conf_int_mac_dot_seq
  import conf_int_mac_dot_seq_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = DW_DEFAULT,
  parameter int Pn                 = PN_DEFAULT,
  parameter int LEN_W              = LEN_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [LEN_W-1:0]              start_len,
  input  logic                          start_apx,
  input  logic [DATA_PATH_BITWIDTH-1:0] start_init,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] op_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] op_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] res_data,
  output logic                          res_apx,
  output logic                          busy,
  output logic [15:0]                   apx_jobs
);

  localparam int DW = DATA_PATH_BITWIDTH;

  state_t         state;
  state_t         state_nxt;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  acc_nxt;
  logic [LEN_W-1:0] remaining;
  logic           mode;
  logic           start_hs;
  logic           op_hs;
  logic           res_hs;

  assign start_hs = start_valid & start_ready;
  assign op_hs    = op_valid & op_ready;
  assign res_hs   = res_valid & res_ready;

  // Result fields only carry the accumulator while a result is offered.
  assign res_data = res_valid ? acc  : '0;
  assign res_apx  = res_valid ? mode : 1'b0;

  conf_int_mac_core #(
    .DW (DW),
    .PN (Pn)
  ) u_core (
    .a   (op_a),
    .b   (op_b),
    .c   (acc),
    .apx (mode),
    .d   (acc_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; readiness depends only on state.
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_nxt = (start_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        op_ready = 1'b1;
        if (op_valid && remaining == LEN_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Job context: latched on start, stepped on each operand, counted on result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      remaining <= '0;
      mode      <= 1'b0;
      apx_jobs  <= '0;
    end else begin
      if (start_hs) begin
        mode      <= start_apx;
        acc       <= start_init;
        remaining <= start_len;
      end else if (op_hs) begin
        acc       <= acc_nxt;
        remaining <= remaining - 1'b1;
      end
      if (res_hs && mode && apx_jobs != 16'hFFFF) apx_jobs <= apx_jobs + 16'd1;
    end
  end

endmodule

// File: tb/tb_conf_int_mac_dot_seq.sv
// Self-checking bench for conf_int_mac_dot_seq: directed jobs plus randomized jobs
// compared against an arithmetic reference model of the multiply-accumulate rules.
module tb_conf_int_mac_dot_seq;

  localparam int DW    = 16;
  localparam int PN    = 6;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             start_apx;
  logic [DW-1:0]    start_init;
  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic             res_apx;
  logic             busy;
  logic [15:0]      apx_jobs;

  int n_checks;
  int n_errors;
  int model_apx_jobs;
  longint vec_a [0:15];
  longint vec_b [0:15];

  conf_int_mac_dot_seq #(
    .DATA_PATH_BITWIDTH (DW),
    .Pn                 (PN),
    .LEN_W              (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .start_apx   (start_apx),
    .start_init  (start_init),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_apx     (res_apx),
    .busy        (busy),
    .apx_jobs    (apx_jobs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step written from the arithmetic rules, not from the RTL.
  function automatic longint ref_step(longint a, longint b, longint c, bit apx);
    longint m;
    longint s;
    m = longint'(1) << DW;
    s = longint'(1) << PN;
    if (!apx) return (a * b + c) % m;
    return (((a / s) * (b / s) + c / (s * s)) * (s * s)) % m;
  endfunction

  // Runs one complete job; operands come from vec_a/vec_b.
  task automatic run_job(input string tag, input int len, input bit apx, input longint init,
                         input bit gap, input int hold, input bit rand_gap);
    longint exp_acc;
    logic [DW-1:0] held;
    exp_acc = init;
    @(negedge clk);
    check({tag, ".idle_start_ready"}, 32'(start_ready), 32'd1);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    start_valid = 1'b1;
    start_len   = LEN_W'(len);
    start_apx   = apx;
    start_init  = DW'(init);
    @(negedge clk);
    start_valid = 1'b0;
    start_apx   = ~apx;
    start_init  = DW'($urandom);
    for (int i = 0; i < len; i++) begin
      if (gap || (rand_gap && $urandom_range(0, 2) == 0)) begin
        op_valid = 1'b0;
        @(negedge clk);
      end
      check({tag, ".run_op_ready"}, 32'(op_ready), 32'd1);
      check({tag, ".run_start_ready"}, 32'(start_ready), 32'd0);
      check({tag, ".run_res_valid"}, 32'(res_valid), 32'd0);
      op_valid = 1'b1;
      op_a     = DW'(vec_a[i]);
      op_b     = DW'(vec_b[i]);
      exp_acc  = ref_step(vec_a[i], vec_b[i], exp_acc, apx);
      @(negedge clk);
      op_valid = 1'b0;
    end
    check({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".res_data"}, 32'(res_data), 32'(exp_acc));
    check({tag, ".res_apx"}, 32'(res_apx), 32'(apx));
    check({tag, ".done_op_ready"}, 32'(op_ready), 32'd0);
    held = res_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ".hold_res_valid"}, 32'(res_valid), 32'd1);
      check({tag, ".hold_res_data"}, 32'(res_data), 32'(held));
      check({tag, ".hold_start_ready"}, 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (apx && model_apx_jobs < 65535) model_apx_jobs++;
    check({tag, ".after_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".after_busy"}, 32'(busy), 32'd0);
    check({tag, ".apx_jobs"}, 32'(apx_jobs), 32'(model_apx_jobs));
  endtask

  initial begin
    int len;
    n_checks       = 0;
    n_errors       = 0;
    model_apx_jobs = 0;
    rst         = 1'b0;
    start_valid = 1'b0;
    start_len   = '0;
    start_apx   = 1'b0;
    start_init  = '0;
    op_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    res_ready   = 1'b0;

    #12;
    check("rst.start_ready", 32'(start_ready), 32'd1);
    check("rst.op_ready", 32'(op_ready), 32'd0);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.res_data", 32'(res_data), 32'd0);
    check("rst.res_apx", 32'(res_apx), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.apx_jobs", 32'(apx_jobs), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Accurate three-term dot product: 5 + 6 + 20 + 1 = 32.
    vec_a[0] = 2; vec_b[0] = 3;
    vec_a[1] = 4; vec_b[1] = 5;
    vec_a[2] = 1; vec_b[2] = 1;
    run_job("acc3", 3, 1'b0, 5, 1'b0, 0, 1'b0);
    check("acc3.const", 32'(dut.res_data), 32'h0);

    // Same operands in both modes show the truncation effect.
    vec_a[0] = 16'h0150; vec_b[0] = 16'h00C0;
    run_job("apx1", 1, 1'b1, 0, 1'b0, 0, 1'b0);
    run_job("apx1_acc", 1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Product wraps modulo 2^16.
    vec_a[0] = 16'hFFFF; vec_b[0] = 2;
    run_job("wrap", 1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Empty job returns the initial value without touching operands.
    run_job("len0", 0, 1'b0, 16'h1234, 1'b0, 0, 1'b0);

    // Gapped operands and a stalled result consumer.
    for (int i = 0; i < 4; i++) begin
      vec_a[i] = $urandom_range(0, 65535);
      vec_b[i] = $urandom_range(0, 65535);
    end
    run_job("bp", 4, 1'b1, 16'h3000, 1'b1, 3, 1'b0);

    // Reset mid-job: two of four operands accepted, then abandon.
    @(negedge clk);
    start_valid = 1'b1; start_len = 8'd4; start_apx = 1'b0; start_init = 16'h0077;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_a = 16'd3; op_b = 16'd9;
      @(negedge clk);
    end
    op_valid = 1'b0;
    check("mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    model_apx_jobs = 0;
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.res_valid", 32'(res_valid), 32'd0);
    check("mid.start_ready", 32'(start_ready), 32'd1);
    check("mid.apx_jobs", 32'(apx_jobs), 32'd0);
    @(negedge clk);
    check("mid.res_valid_held", 32'(res_valid), 32'd0);
    rst = 1'b1;
    vec_a[0] = 10; vec_b[0] = 10;
    vec_a[1] = 7;  vec_b[1] = 3;
    run_job("post_rst", 2, 1'b0, 16'h0100, 1'b0, 1, 1'b0);

    // Randomized jobs in both modes with random gaps and result stalls.
    for (int j = 0; j < 30; j++) begin
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        vec_a[i] = $urandom_range(0, 65535);
        vec_b[i] = $urandom_range(0, 65535);
      end
      run_job("rnd", len, 1'($urandom_range(0, 1)), longint'($urandom_range(0, 65535)),
              1'b0, $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conf_int_mac_dot_seq.md
CONF_INT_MAC_DOT_SEQ -- requirements
Module: conf_int_mac_dot_seq

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 16, operand/accumulator width (DW).
REQ-002 Parameter Pn, default 6, approximate-mode truncation point; 2*Pn < DW SHALL hold.
REQ-003 Parameter LEN_W, default 8, job-length width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start_valid / start_ready  in/out  1/1  job-request handshake.
REQ-007 start_len  in  LEN_W  number of (a,b) operand pairs in the job.
REQ-008 start_apx  in  1  1 = approximate job, 0 = accurate job.
REQ-009 start_init  in  DW  initial accumulator value.
REQ-010 op_valid / op_ready  in/out  1/1  operand-stream handshake.
REQ-011 op_a, op_b  in  DW each  operand pair.
REQ-012 res_valid / res_ready  out/in  1/1  result handshake.
REQ-013 res_data  out  DW  final accumulator; res_apx  out  1  mode of that job.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 apx_jobs  out  16  saturating count of completed approximate jobs.

Function
REQ-016 FSM states IDLE, RUN, DONE; a handshake is valid&ready high on the same rising edge.
REQ-017 start_ready SHALL be 1 only in IDLE; start requests in RUN/DONE are not accepted.
REQ-018 Start handshake SHALL latch start_apx to mode, start_init to acc, start_len to remaining count.
REQ-019 start_len = 0 SHALL go IDLE->DONE with res_data = start_init and no operand consumed.
REQ-020 start_len > 0 SHALL go IDLE->RUN.
REQ-021 op_ready SHALL be 1 only in RUN; one operand pair per cycle maximum.
REQ-022 Each op handshake SHALL update acc <= F(op_a, op_b, acc, mode) and decrement remaining.
REQ-023 Accurate F = (a*b + c) mod 2^DW.
REQ-024 Approximate F = (((a>>Pn)*(b>>Pn) + (c>>(2*Pn))) << (2*Pn)) mod 2^DW.
REQ-025 Op handshake with remaining = 1 SHALL go RUN->DONE; res_valid is high the next cycle.
REQ-026 In RUN with op_valid low, acc and remaining SHALL hold.
REQ-027 In DONE: res_valid = 1, res_data = acc, res_apx = mode, all held stable until the res handshake.
REQ-028 Res handshake SHALL go DONE->IDLE; if mode = 1, apx_jobs increments, saturating at 0xFFFF.
REQ-029 Outside DONE, res_valid SHALL be 0.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, acc 0, remaining 0, mode 0, apx_jobs 0.
REQ-031 Under rst low: start_ready 1, op_ready 0, res_valid 0, res_data 0, res_apx 0, busy 0.
REQ-032 Reset asserted in RUN or DONE SHALL abandon the job; no result is produced.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and default DW/Pn/LEN_W constants.
REQ-034 F SHALL be a purely combinational sub-module conf_int_mac_core (a, b, c, apx -> d); all registers stay in the sequencer.

Verification
REQ-035 Accurate, init=5, len=3, pairs (2,3),(4,5),(1,1) -> res_data=32, res_apx=0, res_valid on cycle after third op handshake.
REQ-036 Approximate, init=0, len=1, a=0x0150, b=0x00C0 -> res_data=0xF000; same stimulus accurate -> 0xFC00; apx_jobs increments only on the approximate job.
REQ-037 Accurate, init=0, len=1, a=0xFFFF, b=2 -> res_data=0xFFFE (wrap).
REQ-038 len=0, init=0x1234 -> DONE next cycle, res_data=0x1234, op_ready never high.
REQ-039 Backpressure: op_valid gapped every other cycle; res_ready low 3 cycles -> result correct, res_data stable, start_ready 0 throughout.
REQ-040 rst pulsed low mid-RUN after 2 of 4 ops -> immediate IDLE, no res_valid; a new job then completes correctly from its own init.
